// File: rtl/seq_detect_rr_sched.sv
// seq_detect_rr_sched: round-robin shared pattern matcher over NCH serial bit streams
module seq_detect_rr_sched #(
  parameter int NCH = 4,
  parameter int PW = 4,
  parameter logic [PW-1:0] DEF_PATTERN = 4'b0110,
  parameter int CW = $clog2(NCH)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en_i,
  input  logic           cfg_we_i,
  input  logic [PW-1:0]  cfg_pattern_i,
  input  logic [NCH-1:0] ch_valid_i,
  input  logic [NCH-1:0] ch_data_i,
  output logic [NCH-1:0] ch_ready_o,
  output logic           match_o,
  output logic [CW-1:0]  match_ch_o,
  output logic [15:0]    match_cnt_o
);
  localparam int FW = $clog2(PW);
  localparam logic [FW-1:0] FILL_MAX = FW'(PW - 1);
  logic [CW-1:0]            ptr_q, ptr_d;
  logic [PW-1:0]            pattern_q, pattern_d;
  logic [NCH-1:0][PW-1:0]   hist_q, hist_d;
  logic [NCH-1:0][FW-1:0]   fill_q, fill_d;
  logic                     match_q, match_d;
  logic [CW-1:0]            match_ch_q, match_ch_d;
  logic [15:0]              match_cnt_q, match_cnt_d;
  logic                     gnt_found;
  logic [CW-1:0]            gnt_idx;
  logic [CW-1:0]            scan_idx;
  logic [PW-1:0]            window;
  logic                     hit;
  // Search for the first valid channel after the pointer, wrapping; grants are suppressed by en or config
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx = '0;
    scan_idx = '0;
    for (int i = 1; i <= NCH; i++) begin
      scan_idx = CW'((int'(ptr_q) + i) % NCH);
      if (!gnt_found && ch_valid_i[scan_idx]) begin
        gnt_found = 1'b1;
        gnt_idx = scan_idx;
      end
    end
    if (!en_i || cfg_we_i) gnt_found = 1'b0;
  end
  // One-hot ready for the granted channel and the match check on its shifted-in window
  always_comb begin
    ch_ready_o = '0;
    if (gnt_found) ch_ready_o[gnt_idx] = 1'b1;
    window = {hist_q[gnt_idx][PW-2:0], ch_data_i[gnt_idx]};
    hit = gnt_found && (fill_q[gnt_idx] == FILL_MAX) && (window == pattern_q);
  end
  // Next state: config clears everything and wins over a grant; otherwise update the granted channel
  always_comb begin
    ptr_d = ptr_q;
    pattern_d = pattern_q;
    hist_d = hist_q;
    fill_d = fill_q;
    match_d = 1'b0;
    match_ch_d = match_ch_q;
    match_cnt_d = match_cnt_q;
    if (cfg_we_i) begin
      pattern_d = cfg_pattern_i;
      hist_d = '0;
      fill_d = '0;
      match_cnt_d = '0;
    end else if (gnt_found) begin
      ptr_d = gnt_idx;
      hist_d[gnt_idx] = window;
      fill_d[gnt_idx] = (fill_q[gnt_idx] == FILL_MAX) ? FILL_MAX : fill_q[gnt_idx] + FW'(1);
      if (hit) begin
        match_d = 1'b1;
        match_ch_d = gnt_idx;
        match_cnt_d = (match_cnt_q == 16'hFFFF) ? match_cnt_q : match_cnt_q + 16'd1;
      end
    end
  end
  // State registers with asynchronous reset; pointer starts at NCH-1 so channel 0 is served first
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= CW'(NCH - 1);
      pattern_q <= DEF_PATTERN;
      hist_q <= '0;
      fill_q <= '0;
      match_q <= 1'b0;
      match_ch_q <= '0;
      match_cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      pattern_q <= pattern_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
      match_q <= match_d;
      match_ch_q <= match_ch_d;
      match_cnt_q <= match_cnt_d;
    end
  end
  assign match_o = match_q;
  assign match_ch_o = match_ch_q;
  assign match_cnt_o = match_cnt_q;
endmodule

// File: tb/tb_seq_detect_rr_sched.sv
// tb_seq_detect_rr_sched: directed self-checking bench for the round-robin pattern matcher
module tb_seq_detect_rr_sched;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        cfg_we = 1'b0;
  logic [3:0]  cfg_pattern = 4'b0;
  logic [3:0]  ch_valid = 4'b0;
  logic [3:0]  ch_data = 4'b0;
  logic [3:0]  ch_ready;
  logic        match;
  logic [1:0]  match_ch;
  logic [15:0] match_cnt;
  int checks = 0;
  int errors = 0;
  logic [3:0] s;
  logic b;
  logic [3:0] bits5;
  seq_detect_rr_sched dut (
    .clk(clk),
    .rst_n(rst_n),
    .en_i(en),
    .cfg_we_i(cfg_we),
    .cfg_pattern_i(cfg_pattern),
    .ch_valid_i(ch_valid),
    .ch_data_i(ch_data),
    .ch_ready_o(ch_ready),
    .match_o(match),
    .match_ch_o(match_ch),
    .match_cnt_o(match_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask
  task automatic cyc(input string tag, input logic [3:0] v, input logic [3:0] d, input logic e,
                     input logic w, input logic [3:0] p, input logic [3:0] er, input logic em,
                     input logic [1:0] ech, input logic [15:0] ecnt);
    ch_valid = v;
    ch_data = d;
    en = e;
    cfg_we = w;
    cfg_pattern = p;
    #1;
    chk({tag, " ready"}, 32'(ch_ready), 32'(er));
    @(posedge clk);
    #1;
    chk({tag, " match"}, 32'(match), 32'(em));
    if (em) chk({tag, " match_ch"}, 32'(match_ch), 32'(ech));
    chk({tag, " cnt"}, 32'(match_cnt), 32'(ecnt));
  endtask
  task automatic rst_pulse(input string tag);
    ch_valid = 4'b0;
    ch_data = 4'b0;
    en = 1'b0;
    cfg_we = 1'b0;
    rst_n = 1'b0;
    #1;
    chk({tag, " rst match"}, 32'(match), 32'd0);
    chk({tag, " rst match_ch"}, 32'(match_ch), 32'd0);
    chk({tag, " rst cnt"}, 32'(match_cnt), 32'd0);
    chk({tag, " rst ready"}, 32'(ch_ready), 32'd0);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask
  initial begin
    @(posedge clk);
    #1;
    rst_pulse("t0");
    // t1: ch0 alone sends 0,1,1,0 against the default pattern
    s = 4'b0110;
    for (int i = 0; i < 4; i++) begin
      b = s[3-i];
      cyc("t1", 4'b0001, {3'b0, b}, 1'b1, 1'b0, 4'b0, 4'b0001, i == 3, 2'd0, (i == 3) ? 16'd1 : 16'd0);
    end
    cyc("t1 idle", 4'b0000, 4'b0000, 1'b1, 1'b0, 4'b0, 4'b0000, 1'b0, 2'd0, 16'd1);
    // t2: ch0 and ch1 contend; grants alternate starting at ch0
    rst_pulse("t2");
    for (int k = 0; k < 8; k++) begin
      int idx;
      idx = (k + 1) / 2;
      b = (idx < 4) ? s[3-idx] : 1'b0;
      cyc("t2", 4'b0011, {2'b0, 1'b1, b}, 1'b1, 1'b0, 4'b0, (k % 2 == 0) ? 4'b0001 : 4'b0010,
          k == 6, 2'd0, (k >= 6) ? 16'd1 : 16'd0);
    end
    // t3: pattern 0000 on ch2; fill qualifier blocks the first three, then overlapping matches
    cyc("t3 cfg", 4'b0100, 4'b0000, 1'b1, 1'b1, 4'b0000, 4'b0000, 1'b0, 2'd0, 16'd0);
    for (int i = 0; i < 5; i++)
      cyc("t3", 4'b0100, 4'b0000, 1'b1, 1'b0, 4'b0, 4'b0100, i >= 3, 2'd2,
          (i == 3) ? 16'd1 : (i == 4) ? 16'd2 : 16'd0);
    // t4: ch3 partial sequence interrupted by config; history restarts
    s = 4'b0110;
    for (int i = 0; i < 3; i++) begin
      b = s[3-i];
      cyc("t4 pre", 4'b1000, {b, 3'b0}, 1'b1, 1'b0, 4'b0, 4'b1000, 1'b0, 2'd0, 16'd2);
    end
    cyc("t4 cfg", 4'b1000, 4'b0000, 1'b1, 1'b1, 4'b0110, 4'b0000, 1'b0, 2'd0, 16'd0);
    bits5 = 4'b0011;
    for (int i = 0; i < 5; i++) begin
      b = (i < 4) ? bits5[3-i] : 1'b0;
      cyc("t4", 4'b1000, {b, 3'b0}, 1'b1, 1'b0, 4'b0, 4'b1000, i == 4, 2'd3, (i == 4) ? 16'd1 : 16'd0);
    end
    // t5: all channels valid, en toggles; pointer resumes in rr order
    cyc("t5 a", 4'b1111, 4'b0000, 1'b1, 1'b0, 4'b0, 4'b0001, 1'b0, 2'd0, 16'd1);
    cyc("t5 off", 4'b1111, 4'b0000, 1'b0, 1'b0, 4'b0, 4'b0000, 1'b0, 2'd0, 16'd1);
    cyc("t5 b", 4'b1111, 4'b0000, 1'b1, 1'b0, 4'b0, 4'b0010, 1'b0, 2'd0, 16'd1);
    cyc("t5 c", 4'b1111, 4'b0000, 1'b1, 1'b0, 4'b0, 4'b0100, 1'b0, 2'd0, 16'd1);
    // t6: reset in the middle of a ch1 sequence discards the partial history
    for (int i = 0; i < 3; i++) begin
      b = s[3-i];
      cyc("t6 pre", 4'b0010, {2'b0, b, 1'b0}, 1'b1, 1'b0, 4'b0, 4'b0010, 1'b0, 2'd0, 16'd1);
    end
    rst_pulse("t6");
    cyc("t6 post", 4'b0010, 4'b0000, 1'b1, 1'b0, 4'b0, 4'b0010, 1'b0, 2'd0, 16'd0);
    chk("t6 match_ch", 32'(match_ch), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
